mem_bus_master: RTL

Initiator side of the processor's data-memory IO bus. Accepts one load/store request at a time from the datapath, drives the bus with read/write enables, a word address, byte enables and lane-replicated write data, and waits out the memory read latency. It then extracts and sign/zero-extends the addressed byte, halfword or word and signals completion. It sits between the execute/memory stage control and the data-memory interface that decodes the user and system regions.

---
 rtl/mem_bus_master.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-request load/store initiator for the data-memory IO bus.
// Define MISALIGN_TRAP_EN to reject misaligned half/word requests instead of aligning them.
module mem_bus_master #(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iWrite,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    input  logic [31:0] iAddress,
    input  logic [31:0] iStoreData,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oLoadData,
    output logic        oMisaligned,
    output logic        wReadEnable,
    output logic        wWriteEnable,
    output logic [3:0]  wByteEnable,
    output logic [31:0] wAddress,
    output logic [31:0] wWriteData,
    input  logic [31:0] wReadData
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} busStateT;

    busStateT    stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic [1:0]  sizeQ, sizeD;
    logic        unsignedQ, unsignedD;
    logic [1:0]  offsetQ, offsetD;
    logic        readEnQ, readEnD;
    logic        writeEnQ, writeEnD;
    logic [3:0]  byteEnQ, byteEnD;
    logic [31:0] addrQ, addrD;
    logic [31:0] writeDataQ, writeDataD;
    logic        doneQ, doneD;
    logic [31:0] loadDataQ, loadDataD;

    // Request decode; the offset is already aligned to the access size.
    logic [1:0]  reqOffset;
    logic [3:0]  reqByteEn;
    logic [31:0] reqWriteData;

    always_comb begin
        reqOffset    = 2'b00;
        reqByteEn    = 4'b1111;
        reqWriteData = iStoreData;
        case (iSize)
            2'b00: begin
                reqOffset    = iAddress[1:0];
                reqByteEn    = 4'b0001 << iAddress[1:0];
                reqWriteData = {4{iStoreData[7:0]}};
            end
            2'b01: begin
                reqOffset    = {iAddress[1], 1'b0};
                reqByteEn    = iAddress[1] ? 4'b1100 : 4'b0011;
                reqWriteData = {2{iStoreData[15:0]}};
            end
            default: begin
                reqOffset    = 2'b00;
                reqByteEn    = 4'b1111;
                reqWriteData = iStoreData;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic reqMisaligned;
    logic misalignedQ, misalignedD;

    assign reqMisaligned = (iSize == 2'b00) ? 1'b0 :
                           (iSize == 2'b01) ? iAddress[0] : (iAddress[1:0] != 2'b00);
`endif

    // Lane extraction and extension of the returned word; X/Z propagate untouched.
    logic [31:0] readShifted;
    logic [31:0] loadExtended;

    always_comb begin
        readShifted = wReadData >> {offsetQ, 3'b000};
        case (sizeQ)
            2'b00:   loadExtended = {{24{~unsignedQ & readShifted[7]}}, readShifted[7:0]};
            2'b01:   loadExtended = {{16{~unsignedQ & readShifted[15]}}, readShifted[15:0]};
            default: loadExtended = readShifted;
        endcase
    end

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        sizeD      = sizeQ;
        unsignedD  = unsignedQ;
        offsetD    = offsetQ;
        readEnD    = 1'b0;
        writeEnD   = 1'b0;
        byteEnD    = 4'b0000;
        addrD      = 32'h0;
        writeDataD = 32'h0;
        doneD      = 1'b0;
        loadDataD  = loadDataQ;
`ifdef MISALIGN_TRAP_EN
        misalignedD = 1'b0;
`endif
        case (stateQ)
            StIdle: begin
                if (iStart) begin
                    sizeD     = iSize;
                    unsignedD = iUnsigned;
                    offsetD   = reqOffset;
`ifdef MISALIGN_TRAP_EN
                    if (reqMisaligned) begin
                        stateD      = StDone;
                        doneD       = 1'b1;
                        misalignedD = 1'b1;
                    end else
`endif
                    if (iWrite) begin
                        stateD     = StWrite;
                        writeEnD   = 1'b1;
                        byteEnD    = reqByteEn;
                        addrD      = {iAddress[31:2], 2'b00};
                        writeDataD = reqWriteData;
                    end else begin
                        stateD  = StRead;
                        readEnD = 1'b1;
                        byteEnD = reqByteEn;
                        addrD   = {iAddress[31:2], 2'b00};
                        cntD    = 4'(READ_LATENCY - 1);
                    end
                end
            end
            StWrite: begin
                stateD = StDone;
                doneD  = 1'b1;
            end
            StRead: begin
                if (cntQ == 4'd0) begin
                    stateD    = StDone;
                    doneD     = 1'b1;
                    loadDataD = loadExtended;
                end else begin
                    cntD    = cntQ - 4'd1;
                    readEnD = 1'b1;
                    byteEnD = byteEnQ;
                    addrD   = addrQ;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ     <= StIdle;
            cntQ       <= 4'd0;
            sizeQ      <= 2'b00;
            unsignedQ  <= 1'b0;
            offsetQ    <= 2'b00;
            readEnQ    <= 1'b0;
            writeEnQ   <= 1'b0;
            byteEnQ    <= 4'b0000;
            addrQ      <= 32'h0;
            writeDataQ <= 32'h0;
            doneQ      <= 1'b0;
            loadDataQ  <= 32'h0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            sizeQ      <= sizeD;
            unsignedQ  <= unsignedD;
            offsetQ    <= offsetD;
            readEnQ    <= readEnD;
            writeEnQ   <= writeEnD;
            byteEnQ    <= byteEnD;
            addrQ      <= addrD;
            writeDataQ <= writeDataD;
            doneQ      <= doneD;
            loadDataQ  <= loadDataD;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            misalignedQ <= 1'b0;
        end else begin
            misalignedQ <= misalignedD;
        end
    end

    assign oMisaligned = misalignedQ;
`else
    assign oMisaligned = 1'b0;
`endif

    assign oBusy        = (stateQ != StIdle);
    assign oDone        = doneQ;
    assign oLoadData    = loadDataQ;
    assign wReadEnable  = readEnQ;
    assign wWriteEnable = writeEnQ;
    assign wByteEnable  = byteEnQ;
    assign wAddress     = addrQ;
    assign wWriteData   = writeDataQ;

endmodule
